// File: rtl/lsu_axi_rd_arb.sv
// lsu_axi_rd_arb
//   Read-channel scheduler for the LSU. Two load engines (0 = IRAM fill,
//   1 = WRAM fill) share one AXI AR/R port. AR requests are arbitrated
//   round-robin with a per-requester cap on outstanding bursts. R beats
//   are steered back to their owner by rid; foreign IDs are drained.
//
// Ports
//   clk, rst_n              core clock, asynchronous active-low reset
//   req_vld / req_rdy       per-requester request valid / one-cycle grant
//   reqN_addr/len/num/str   per-requester burst payload
//   lsu_axi_ar*             AXI read-address channel (registered)
//   axi_lsu_r*, lsu_axi_rrdy AXI read-data channel
//   rsp_vld / rsp_rdy       per-requester beat handshake
//   rsp_data/last/err       shared beat payload, err = (rresp != OKAY)
//   err_unexp_rid           sticky: foreign rid beat or stray rlast
//   rd_timeout              sticky watchdog flag
//
// Build option
//   LSU_RD_ARB_TIMEOUT_EN   enables the read watchdog; otherwise
//                           rd_timeout is tied low.
module lsu_axi_rd_arb #(
  parameter logic [6:0]  ID_BASE     = 7'h20,
  parameter int unsigned MAX_OUTST   = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_vld,
  output logic [1:0]  req_rdy,
  input  logic [9:0]  req0_addr,
  input  logic [9:0]  req1_addr,
  input  logic [7:0]  req0_len,
  input  logic [7:0]  req1_len,
  input  logic [7:0]  req0_num,
  input  logic [7:0]  req1_num,
  input  logic [2:0]  req0_str,
  input  logic [2:0]  req1_str,
  output logic [7:0]  lsu_axi_arid,
  output logic [9:0]  lsu_axi_araddr,
  output logic [7:0]  lsu_axi_arlen,
  output logic [2:0]  lsu_axi_arsize,
  output logic [1:0]  lsu_axi_arburst,
  output logic [2:0]  lsu_axi_arstr,
  output logic [7:0]  lsu_axi_arnum,
  output logic        lsu_axi_arvld,
  input  logic        axi_lsu_arrdy,
  input  logic [7:0]  axi_lsu_rid,
  input  logic [63:0] axi_lsu_rdata,
  input  logic [1:0]  axi_lsu_rresp,
  input  logic        axi_lsu_rlast,
  input  logic        axi_lsu_rvld,
  output logic        lsu_axi_rrdy,
  output logic [1:0]  rsp_vld,
  input  logic [1:0]  rsp_rdy,
  output logic [63:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        err_unexp_rid,
  output logic        rd_timeout
);

  localparam logic [3:0] MAX_Q = 4'(MAX_OUTST);

  typedef enum logic {
    S_IDLE,
    S_AR_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [3:0]  outst0_q, outst0_d;
  logic [3:0]  outst1_q, outst1_d;
  logic        err_q, err_d;

  logic [7:0]  arid_q, arid_d;
  logic [9:0]  araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [1:0]  arburst_q, arburst_d;
  logic [2:0]  arstr_q, arstr_d;
  logic [7:0]  arnum_q, arnum_d;
  logic        arvld_q, arvld_d;

  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        gnt_src;
  logic        ar_hs;
  logic        rid_match;
  logic        rid_owner;
  logic        r_hs;
  logic        burst_done;
  logic        inc0, inc1, dec0, dec1;
  logic        stray0, stray1;

  // Arbitration
  always_comb begin
    elig[0] = req_vld[0] && (outst0_q < MAX_Q);
    elig[1] = req_vld[1] && (outst1_q < MAX_Q);
    grant   = 2'b00;
    if (state_q == S_IDLE) begin
      if (elig == 2'b11) grant = rr_ptr_q ? 2'b10 : 2'b01;
      else               grant = elig;
    end
    gnt_src = grant[1];
  end

  // Grant is combinational; masked so nothing is accepted during reset.
  assign req_rdy = grant & {2{rst_n}};

  // AR FSM and payload capture
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arstr_d   = arstr_q;
    arnum_d   = arnum_q;
    arvld_d   = arvld_q;
    case (state_q)
      S_IDLE: begin
        if (grant != 2'b00) begin
          arid_d    = {ID_BASE, gnt_src};
          araddr_d  = gnt_src ? req1_addr : req0_addr;
          arlen_d   = gnt_src ? req1_len  : req0_len;
          arnum_d   = gnt_src ? req1_num  : req0_num;
          arstr_d   = gnt_src ? req1_str  : req0_str;
          arsize_d  = 3'd3;
          arburst_d = 2'b01;
          arvld_d   = 1'b1;
          rr_ptr_d  = ~gnt_src;
          state_d   = S_AR_WAIT;
        end
      end
      S_AR_WAIT: begin
        if (axi_lsu_arrdy) begin
          arvld_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ar_hs = arvld_q && axi_lsu_arrdy;

  // R steering
  always_comb begin
    rid_match = (axi_lsu_rid[7:1] == ID_BASE);
    rid_owner = axi_lsu_rid[0];
    rsp_vld   = 2'b00;
    if (rid_match) begin
      rsp_vld[rid_owner] = axi_lsu_rvld;
      lsu_axi_rrdy       = rsp_rdy[rid_owner];
    end else begin
      lsu_axi_rrdy = 1'b1;
    end
  end

  assign rsp_data   = axi_lsu_rdata;
  assign rsp_last   = axi_lsu_rlast;
  assign rsp_err    = |axi_lsu_rresp;
  assign r_hs       = axi_lsu_rvld && lsu_axi_rrdy;
  assign burst_done = r_hs && axi_lsu_rlast && rid_match;

  // Outstanding counters. Inc and dec together cancel; a dec with
  // nothing outstanding is a stray rlast and is flagged instead.
  always_comb begin
    inc0   = ar_hs && !arid_q[0];
    inc1   = ar_hs &&  arid_q[0];
    dec0   = burst_done && !rid_owner;
    dec1   = burst_done &&  rid_owner;
    stray0 = dec0 && !inc0 && (outst0_q == 4'd0);
    stray1 = dec1 && !inc1 && (outst1_q == 4'd0);

    outst0_d = outst0_q;
    if (inc0 && !dec0)                         outst0_d = outst0_q + 4'd1;
    else if (dec0 && !inc0 && outst0_q != 4'd0) outst0_d = outst0_q - 4'd1;

    outst1_d = outst1_q;
    if (inc1 && !dec1)                         outst1_d = outst1_q + 4'd1;
    else if (dec1 && !inc1 && outst1_q != 4'd0) outst1_d = outst1_q - 4'd1;

    err_d = err_q || (axi_lsu_rvld && !rid_match) || stray0 || stray1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= 1'b0;
      outst0_q  <= '0;
      outst1_q  <= '0;
      err_q     <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arstr_q   <= '0;
      arnum_q   <= '0;
      arvld_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      outst0_q  <= outst0_d;
      outst1_q  <= outst1_d;
      err_q     <= err_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      arstr_q   <= arstr_d;
      arnum_q   <= arnum_d;
      arvld_q   <= arvld_d;
    end
  end

  assign lsu_axi_arid    = arid_q;
  assign lsu_axi_araddr  = araddr_q;
  assign lsu_axi_arlen   = arlen_q;
  assign lsu_axi_arsize  = arsize_q;
  assign lsu_axi_arburst = arburst_q;
  assign lsu_axi_arstr   = arstr_q;
  assign lsu_axi_arnum   = arnum_q;
  assign lsu_axi_arvld   = arvld_q;
  assign err_unexp_rid   = err_q;

`ifdef LSU_RD_ARB_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        rd_to_q, rd_to_d;
  logic        busy;

  // Counts idle cycles while bursts are pending; any R handshake restarts it.
  always_comb begin
    busy    = (outst0_q != 4'd0) || (outst1_q != 4'd0);
    wdog_d  = wdog_q;
    rd_to_d = rd_to_q;
    if (!busy || r_hs) begin
      wdog_d = '0;
    end else begin
      if (wdog_q != 16'hFFFF) wdog_d = wdog_q + 16'd1;
      if (({16'd0, wdog_q} + 32'd1) >= 32'(TIMEOUT_CYC)) rd_to_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q  <= '0;
      rd_to_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      rd_to_q <= rd_to_d;
    end
  end

  assign rd_timeout = rd_to_q;
`else
  assign rd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_axi_rd_arb.sv
module tb_lsu_axi_rd_arb;

  typedef struct packed {
    logic [7:0] id;
    logic [9:0] addr;
    logic [7:0] len;
    logic [7:0] num;
    logic [2:0] str;
  } ar_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_vld;
  logic [1:0]  req_rdy;
  logic [9:0]  req0_addr, req1_addr;
  logic [7:0]  req0_len, req1_len;
  logic [7:0]  req0_num, req1_num;
  logic [2:0]  req0_str, req1_str;
  logic [7:0]  lsu_axi_arid;
  logic [9:0]  lsu_axi_araddr;
  logic [7:0]  lsu_axi_arlen;
  logic [2:0]  lsu_axi_arsize;
  logic [1:0]  lsu_axi_arburst;
  logic [2:0]  lsu_axi_arstr;
  logic [7:0]  lsu_axi_arnum;
  logic        lsu_axi_arvld;
  logic        axi_lsu_arrdy;
  logic [7:0]  axi_lsu_rid;
  logic [63:0] axi_lsu_rdata;
  logic [1:0]  axi_lsu_rresp;
  logic        axi_lsu_rlast;
  logic        axi_lsu_rvld;
  logic        lsu_axi_rrdy;
  logic [1:0]  rsp_vld;
  logic [1:0]  rsp_rdy;
  logic [63:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        err_unexp_rid;
  logic        rd_timeout;

  int errors;
  int checks;

  ar_t         ar_q[$];
  logic [64:0] r_q[$];   // {last, data}

  lsu_axi_rd_arb #(
    .ID_BASE     (7'h20),
    .MAX_OUTST   (4),
`ifdef LSU_RD_ARB_TIMEOUT_EN
    .TIMEOUT_CYC (16)
`else
    .TIMEOUT_CYC (1024)
`endif
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_vld         (req_vld),
    .req_rdy         (req_rdy),
    .req0_addr       (req0_addr),
    .req1_addr       (req1_addr),
    .req0_len        (req0_len),
    .req1_len        (req1_len),
    .req0_num        (req0_num),
    .req1_num        (req1_num),
    .req0_str        (req0_str),
    .req1_str        (req1_str),
    .lsu_axi_arid    (lsu_axi_arid),
    .lsu_axi_araddr  (lsu_axi_araddr),
    .lsu_axi_arlen   (lsu_axi_arlen),
    .lsu_axi_arsize  (lsu_axi_arsize),
    .lsu_axi_arburst (lsu_axi_arburst),
    .lsu_axi_arstr   (lsu_axi_arstr),
    .lsu_axi_arnum   (lsu_axi_arnum),
    .lsu_axi_arvld   (lsu_axi_arvld),
    .axi_lsu_arrdy   (axi_lsu_arrdy),
    .axi_lsu_rid     (axi_lsu_rid),
    .axi_lsu_rdata   (axi_lsu_rdata),
    .axi_lsu_rresp   (axi_lsu_rresp),
    .axi_lsu_rlast   (axi_lsu_rlast),
    .axi_lsu_rvld    (axi_lsu_rvld),
    .lsu_axi_rrdy    (lsu_axi_rrdy),
    .rsp_vld         (rsp_vld),
    .rsp_rdy         (rsp_rdy),
    .rsp_data        (rsp_data),
    .rsp_last        (rsp_last),
    .rsp_err         (rsp_err),
    .err_unexp_rid   (err_unexp_rid),
    .rd_timeout      (rd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Advance to the drive point just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_vld       = 2'b00;
    req0_addr     = '0; req1_addr = '0;
    req0_len      = '0; req1_len  = '0;
    req0_num      = '0; req1_num  = '0;
    req0_str      = '0; req1_str  = '0;
    axi_lsu_arrdy = 1'b0;
    axi_lsu_rid   = '0;
    axi_lsu_rdata = '0;
    axi_lsu_rresp = '0;
    axi_lsu_rlast = 1'b0;
    axi_lsu_rvld  = 1'b0;
    rsp_rdy       = 2'b00;
  endtask

  task automatic do_reset();
    clear_inputs();
    ar_q.delete();
    r_q.delete();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic ar_t obs_ar();
    return {lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arnum, lsu_axi_arstr};
  endfunction

  task automatic pop_check_ar(input string name);
    ar_t e;
    checks++;
    if (ar_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected AR handshake arid=%h araddr=%h", name, lsu_axi_arid, lsu_axi_araddr);
    end else begin
      e = ar_q.pop_front();
      if (obs_ar() !== e) begin
        errors++;
        $display("FAIL %s: got ar=%h want ar=%h", name, obs_ar(), e);
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n   = 1'b0;
    req_vld = 2'b11;
    repeat (2) @(negedge clk);
    checks++;
    if ({lsu_axi_arvld, lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
         lsu_axi_arburst, lsu_axi_arstr, lsu_axi_arnum} !== '0) begin
      errors++;
      $display("FAIL reset_ar: got arvld=%b arid=%h araddr=%h want all zero", lsu_axi_arvld, lsu_axi_arid, lsu_axi_araddr);
    end
    checks++;
    if (req_rdy !== 2'b00) begin
      errors++;
      $display("FAIL reset_req_rdy: got %b want 00", req_rdy);
    end
    checks++;
    if ({err_unexp_rid, rd_timeout} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got err=%b to=%b want 0 0", err_unexp_rid, rd_timeout);
    end
    tick();
    req_vld = 2'b00;
    rst_n   = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req0_addr = 10'h040; req0_len = 8'd7; req0_num = 8'd4; req0_str = 3'd1;
    req_vld   = 2'b01;
    ar_q.push_back('{id: 8'h40, addr: 10'h040, len: 8'd7, num: 8'd4, str: 3'd1});
    @(negedge clk);
    checks++;
    if (req_rdy !== 2'b01) begin
      errors++;
      $display("FAIL single_grant: got req_rdy=%b want 01", req_rdy);
    end
    tick();
    req_vld = 2'b00;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (lsu_axi_arvld !== 1'b1 || ar_q.size() == 0 || obs_ar() !== ar_q[0]) begin
        errors++;
        $display("FAIL single_ar_hold: cycle %0d arvld=%b ar=%h", c, lsu_axi_arvld, obs_ar());
      end
      tick();
    end
    axi_lsu_arrdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({lsu_axi_arsize, lsu_axi_arburst} !== {3'd3, 2'b01}) begin
      errors++;
      $display("FAIL single_fixed: got arsize=%0d arburst=%0d want 3 1", lsu_axi_arsize, lsu_axi_arburst);
    end
    if (lsu_axi_arvld === 1'b1) pop_check_ar("single_ar");
    else begin
      checks++; errors++;
      $display("FAIL single_ar: arvld dropped before arrdy");
    end
    tick();
    axi_lsu_arrdy = 1'b0;
    @(negedge clk);
    checks++;
    if (lsu_axi_arvld !== 1'b0) begin
      errors++;
      $display("FAIL single_arvld_clear: got %b want 0", lsu_axi_arvld);
    end
    tick();
    rsp_rdy = 2'b01;
    for (int k = 0; k < 8; k++) begin
      axi_lsu_rvld  = 1'b1;
      axi_lsu_rid   = 8'h40;
      axi_lsu_rdata = 64'hD000_0000_0000_0000 | 64'(k);
      axi_lsu_rlast = (k == 7);
      r_q.push_back({(k == 7), 64'hD000_0000_0000_0000 | 64'(k)});
      @(negedge clk);
      checks++;
      if (rsp_vld !== 2'b01 || lsu_axi_rrdy !== 1'b1 || r_q.size() == 0) begin
        errors++;
        $display("FAIL single_beat_vld: beat %0d rsp_vld=%b rrdy=%b", k, rsp_vld, lsu_axi_rrdy);
      end else begin
        logic [64:0] e;
        e = r_q.pop_front();
        if ({rsp_last, rsp_data} !== e) begin
          errors++;
          $display("FAIL single_beat_data: beat %0d got %h want %h", k, {rsp_last, rsp_data}, e);
        end
      end
      tick();
    end
    axi_lsu_rvld  = 1'b0;
    axi_lsu_rlast = 1'b0;
    @(negedge clk);
    checks++;
    if (err_unexp_rid !== 1'b0) begin
      errors++;
      $display("FAIL single_no_stray: got err=%b want 0", err_unexp_rid);
    end
    // Counter is back at 0, so one more rlast is stray.
    tick();
    axi_lsu_rvld = 1'b1; axi_lsu_rlast = 1'b1;
    tick();
    axi_lsu_rvld = 1'b0; axi_lsu_rlast = 1'b0;
    @(negedge clk);
    checks++;
    if (err_unexp_rid !== 1'b1) begin
      errors++;
      $display("FAIL single_outst_zero: got err=%b want 1", err_unexp_rid);
    end
    tick();
  endtask

  task automatic test_contention();
    int n;
    do_reset();
    req0_addr = 10'h100; req0_len = 8'd3; req0_num = 8'd2; req0_str = 3'd2;
    req1_addr = 10'h200; req1_len = 8'd1; req1_num = 8'd5; req1_str = 3'd4;
    for (int g = 0; g < 4; g++) begin
      if (g % 2 == 0) ar_q.push_back('{id: 8'h40, addr: 10'h100, len: 8'd3, num: 8'd2, str: 3'd2});
      else            ar_q.push_back('{id: 8'h41, addr: 10'h200, len: 8'd1, num: 8'd5, str: 3'd4});
    end
    axi_lsu_arrdy = 1'b1;
    req_vld       = 2'b11;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (lsu_axi_arvld === 1'b1) begin
        pop_check_ar("contention_ar");
        n++;
      end
      tick();
    end
    req_vld = 2'b00;
    axi_lsu_arrdy = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL contention_count: got %0d handshakes want 4", n);
    end
    tick();
  endtask

  task automatic test_full();
    int n;
    logic got1;
    do_reset();
    req0_addr = 10'h0A0; req0_len = 8'd15; req0_num = 8'd1; req0_str = 3'd0;
    req1_addr = 10'h1C0; req1_len = 8'd2;  req1_num = 8'd3; req1_str = 3'd5;
    for (int g = 0; g < 4; g++)
      ar_q.push_back('{id: 8'h40, addr: 10'h0A0, len: 8'd15, num: 8'd1, str: 3'd0});
    axi_lsu_arrdy = 1'b1;
    req_vld       = 2'b01;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (lsu_axi_arvld === 1'b1) begin
        pop_check_ar("full_ar0");
        n++;
      end
      tick();
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL full_count: got %0d src0 ARs want 4", n);
    end
    @(negedge clk);
    checks++;
    if (req_rdy !== 2'b00) begin
      errors++;
      $display("FAIL full_block: got req_rdy=%b want 00", req_rdy);
    end
`ifndef LSU_RD_ARB_TIMEOUT_EN
    checks++;
    if (rd_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_tied: got %b want 0", rd_timeout);
    end
`endif
    tick();
    // Requester 1 must still get through while 0 is full.
    ar_q.push_back('{id: 8'h41, addr: 10'h1C0, len: 8'd2, num: 8'd3, str: 3'd5});
    req_vld = 2'b11;
    got1 = 1'b0;
    for (int c = 0; c < 10 && !got1; c++) begin
      logic saw_gnt;
      @(negedge clk);
      saw_gnt = req_rdy[1];
      if (lsu_axi_arvld === 1'b1) begin
        pop_check_ar("full_ar1");
        got1 = 1'b1;
      end
      tick();
      if (saw_gnt) req_vld = 2'b01;
    end
    req_vld = 2'b01;
    checks++;
    if (!got1) begin
      errors++;
      $display("FAIL full_other: got no src1 AR want 1");
    end
    // Retire one src0 burst: exactly one more src0 grant follows.
    ar_q.push_back('{id: 8'h40, addr: 10'h0A0, len: 8'd15, num: 8'd1, str: 3'd0});
    rsp_rdy = 2'b01;
    axi_lsu_rvld = 1'b1; axi_lsu_rid = 8'h40; axi_lsu_rlast = 1'b1;
    tick();
    axi_lsu_rvld = 1'b0; axi_lsu_rlast = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (lsu_axi_arvld === 1'b1) begin
        pop_check_ar("full_refill");
        n++;
      end
      tick();
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL full_refill_count: got %0d want 1", n);
    end
    req_vld = 2'b00;
    axi_lsu_arrdy = 1'b0;
    tick();
  endtask

  task automatic test_steer();
    logic [64:0] e;
    do_reset();
    rsp_rdy       = 2'b00;
    axi_lsu_rvld  = 1'b1;
    axi_lsu_rid   = 8'h41;
    axi_lsu_rdata = 64'h1111_2222_3333_4444;
    r_q.push_back({1'b0, 64'h1111_2222_3333_4444});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (lsu_axi_rrdy !== 1'b0 || rsp_vld !== 2'b10 || rsp_data !== r_q[0][63:0]) begin
        errors++;
        $display("FAIL steer_stall: cycle %0d rrdy=%b rsp_vld=%b data=%h", c, lsu_axi_rrdy, rsp_vld, rsp_data);
      end
      tick();
    end
    rsp_rdy = 2'b10;
    @(negedge clk);
    e = r_q.pop_front();
    checks++;
    if (lsu_axi_rrdy !== 1'b1 || {rsp_last, rsp_data} !== e) begin
      errors++;
      $display("FAIL steer_release: rrdy=%b got %h want %h", lsu_axi_rrdy, {rsp_last, rsp_data}, e);
    end
    tick();
    axi_lsu_rid = 8'h40; axi_lsu_rdata = 64'h5555_0000_0000_5555; rsp_rdy = 2'b01;
    r_q.push_back({1'b0, 64'h5555_0000_0000_5555});
    @(negedge clk);
    e = r_q.pop_front();
    checks++;
    if (rsp_vld !== 2'b01 || {rsp_last, rsp_data} !== e) begin
      errors++;
      $display("FAIL steer_interleave: rsp_vld=%b got %h want %h", rsp_vld, {rsp_last, rsp_data}, e);
    end
    tick();
    axi_lsu_rid = 8'h41; axi_lsu_rdata = 64'h6666; axi_lsu_rresp = 2'b10; rsp_rdy = 2'b10;
    @(negedge clk);
    checks++;
    if (rsp_err !== 1'b1 || rsp_vld !== 2'b10) begin
      errors++;
      $display("FAIL steer_err: rsp_err=%b rsp_vld=%b want 1 10", rsp_err, rsp_vld);
    end
    tick();
    axi_lsu_rresp = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL steer_ok: rsp_err=%b want 0", rsp_err);
    end
    tick();
    axi_lsu_rvld = 1'b0;
    @(negedge clk);
    checks++;
    if (err_unexp_rid !== 1'b0) begin
      errors++;
      $display("FAIL steer_no_err: got %b want 0", err_unexp_rid);
    end
    tick();
  endtask

  task automatic test_foreign_reset();
    logic seen;
    do_reset();
    rsp_rdy      = 2'b00;
    axi_lsu_rvld = 1'b1;
    axi_lsu_rid  = 8'h05;
    @(negedge clk);
    checks++;
    if (lsu_axi_rrdy !== 1'b1 || rsp_vld !== 2'b00) begin
      errors++;
      $display("FAIL foreign_drop: rrdy=%b rsp_vld=%b want 1 00", lsu_axi_rrdy, rsp_vld);
    end
    tick();
    axi_lsu_rvld = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (err_unexp_rid !== 1'b1) begin
      errors++;
      $display("FAIL foreign_sticky: got %b want 1", err_unexp_rid);
    end
    tick();
    // One completed AR, then a second one caught in AR_WAIT by reset.
    req0_addr = 10'h3F0; req0_len = 8'd1; req0_num = 8'd1; req0_str = 3'd7;
    req_vld = 2'b01;
    axi_lsu_arrdy = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (lsu_axi_arvld === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL foreign_first_ar: got no AR handshake want 1");
    end
    axi_lsu_arrdy = 1'b0;
    tick();
    req_vld = 2'b00;
    @(negedge clk);
    checks++;
    if (lsu_axi_arvld !== 1'b1) begin
      errors++;
      $display("FAIL foreign_ar_wait: arvld=%b want 1", lsu_axi_arvld);
    end
    tick();
    rst_n   = 1'b0;
    req_vld = 2'b01;
    #1;
    checks++;
    if ({lsu_axi_arvld, lsu_axi_araddr, err_unexp_rid, req_rdy} !== '0) begin
      errors++;
      $display("FAIL async_reset: arvld=%b araddr=%h err=%b req_rdy=%b want all 0",
               lsu_axi_arvld, lsu_axi_araddr, err_unexp_rid, req_rdy);
    end
    tick();
    tick();
    rst_n   = 1'b1;
    req_vld = 2'b00;
    tick();
    // Counter was cleared, so a late rlast for src0 is forwarded but stray.
    rsp_rdy = 2'b01;
    axi_lsu_rvld = 1'b1; axi_lsu_rid = 8'h40; axi_lsu_rlast = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_vld !== 2'b01) begin
      errors++;
      $display("FAIL late_beat_fwd: rsp_vld=%b want 01", rsp_vld);
    end
    tick();
    axi_lsu_rvld = 1'b0; axi_lsu_rlast = 1'b0;
    @(negedge clk);
    checks++;
    if (err_unexp_rid !== 1'b1) begin
      errors++;
      $display("FAIL late_beat_stray: err=%b want 1", err_unexp_rid);
    end
    tick();
  endtask

`ifdef LSU_RD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic seen;
    do_reset();
    req0_addr = 10'h010; req0_len = 8'd0; req0_num = 8'd1; req0_str = 3'd0;
    req_vld = 2'b01;
    axi_lsu_arrdy = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (lsu_axi_arvld === 1'b1) seen = 1'b1;
      tick();
      req_vld = 2'b00;
    end
    axi_lsu_arrdy = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_ar: got no AR handshake want 1");
    end
    repeat (8) tick();
    checks++;
    if (rd_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b want 0", rd_timeout);
    end
    rsp_rdy = 2'b01;
    axi_lsu_rvld = 1'b1; axi_lsu_rid = 8'h40; axi_lsu_rlast = 1'b0;
    tick();
    axi_lsu_rvld = 1'b0;
    repeat (14) tick();
    checks++;
    if (rd_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_restart: got %b want 0", rd_timeout);
    end
    repeat (4) tick();
    checks++;
    if (rd_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: got %b want 1", rd_timeout);
    end
    repeat (3) tick();
    checks++;
    if (rd_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b want 1", rd_timeout);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_steer();
    test_foreign_reset();
`ifdef LSU_RD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
